// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline stages and the stall/flush sequencer.
//   Requests (pipeline -> sequencer):
//     stallreq_id     ID load-use hazard stall request
//     stallreq_ex     EX multi-cycle busy stall request
//     excp_i          exception taken in MEM
//     excp_handler_i  exception handler address
//     eret_i          eret retiring in MEM
//     epc_i           return address for eret
//   Controls (sequencer -> pipeline):
//     stall_o         per-stage hold enables (pc, if_id, id_ex, ex_mem, mem_wb, reserved)
//     flush_o         clear all pipeline registers
//     new_pc_o        redirect target, valid while flush_o=1
//     ex_abort_o      one-cycle cancel of the EX multi-cycle op
//     stall_cnt_o     saturating count of stalled cycles
// The master modport is the pipeline side; the slave modport is the sequencer.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             excp_i;
  logic [31:0]      excp_handler_i;
  logic             eret_i;
  logic [31:0]      epc_i;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic [31:0]      new_pc_o;
  logic             ex_abort_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output stallreq_id, stallreq_ex, excp_i, excp_handler_i, eret_i, epc_i,
    input  stall_o, flush_o, new_pc_o, ex_abort_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, excp_i, excp_handler_i, eret_i, epc_i,
    output stall_o, flush_o, new_pc_o, ex_abort_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage pipeline.
//   clk  rising-edge system clock
//   rst  asynchronous active-low reset
//   bus  pipe_ctrl_if.slave: stall requests and MEM exception/eret events in;
//        per-stage stall vector, flush pulse with redirect PC, EX watchdog
//        abort and saturating stall-cycle counter out.
// stall_o is combinational (same-cycle response to requests); every other
// output is registered.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_MAX     = 64,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam int WDOG_W = $clog2(WDOG_MAX + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state_reg;
  logic              flush_reg;
  logic [31:0]       new_pc_reg;
  logic              abort_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [WDOG_W-1:0] wdog_reg;
  logic [2:0]        flush_cnt_reg;
  logic [5:0]        stall_next;
  logic              redirect;

  assign redirect = bus.excp_i | bus.eret_i;

  // Stall vector: a redirect squashes everything, so nothing is held in that
  // cycle; EX outranks ID because holding ex_mem also covers the ID hazard.
  always_comb begin
    stall_next = 6'b000000;
    if (rst && (state_reg == RUN) && !redirect) begin
      if (bus.stallreq_ex) begin
        stall_next = 6'b001111;
      end else if (bus.stallreq_id) begin
        stall_next = 6'b000111;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      flush_reg     <= 1'b0;
      new_pc_reg    <= 32'h0;
      abort_reg     <= 1'b0;
      cnt_reg       <= '0;
      wdog_reg      <= '0;
      flush_cnt_reg <= 3'd0;
    end else begin
      abort_reg <= 1'b0;

      if ((stall_next != 6'b000000) && !(&cnt_reg)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      case (state_reg)
        RUN: begin
          if (redirect) begin
            state_reg     <= FLUSH;
            flush_reg     <= 1'b1;
            new_pc_reg    <= bus.excp_i ? bus.excp_handler_i : bus.epc_i;
            flush_cnt_reg <= 3'd0;
            wdog_reg      <= '0;
          end else if (bus.stallreq_ex) begin
            // Count reaching WDOG_MAX on this edge: fire abort and restart.
            if (wdog_reg == WDOG_W'(WDOG_MAX - 1)) begin
              wdog_reg  <= '0;
              abort_reg <= 1'b1;
            end else begin
              wdog_reg <= wdog_reg + 1'b1;
            end
          end else begin
            wdog_reg <= '0;
          end
        end
        FLUSH: begin
          // Requests are ignored here: the instructions raising them are
          // being squashed.
          if (flush_cnt_reg == 3'(FLUSH_CYCLES - 1)) begin
            state_reg     <= RUN;
            flush_reg     <= 1'b0;
            flush_cnt_reg <= 3'd0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign bus.stall_o     = stall_next;
  assign bus.flush_o     = flush_reg;
  assign bus.new_pc_o    = new_pc_reg;
  assign bus.ex_abort_o  = abort_reg;
  assign bus.stall_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. dut_a (FLUSH_CYCLES=1, WDOG_MAX=4, CNT_W=4) runs a
// per-cycle vector table; dut_b (FLUSH_CYCLES=3) checks multi-cycle flush.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id, ex, excp, eret;
  logic [31:0] handler, epc;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(4))  bus_a ();
  pipe_ctrl_if #(.CNT_W(16)) bus_b ();

  assign bus_a.stallreq_id    = id;
  assign bus_a.stallreq_ex    = ex;
  assign bus_a.excp_i         = excp;
  assign bus_a.excp_handler_i = handler;
  assign bus_a.eret_i         = eret;
  assign bus_a.epc_i          = epc;
  assign bus_b.stallreq_id    = id;
  assign bus_b.stallreq_ex    = ex;
  assign bus_b.excp_i         = excp;
  assign bus_b.excp_handler_i = handler;
  assign bus_b.eret_i         = eret;
  assign bus_b.epc_i          = epc;

  pipe_ctrl #(.FLUSH_CYCLES(1), .WDOG_MAX(4), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_a.slave)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .WDOG_MAX(4), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_b.slave)
  );

  typedef struct {
    logic        rst_n, id, ex, excp, eret;
    logic [31:0] handler, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        abort;
  } vec_t;

  typedef struct {
    int          idx;
    logic        flush;
    logic [31:0] pc;
    logic        abort;
    logic [3:0]  cnt;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];
  int    tests = 0;
  int    fails = 0;

  function automatic vec_t mk(logic r, logic i, logic e, logic x, logic er,
                              logic [31:0] h, logic [31:0] ep, logic [5:0] s,
                              logic f, logic [31:0] pc, logic a);
    vec_t v;
    v.rst_n = r; v.id = i; v.ex = e; v.excp = x; v.eret = er;
    v.handler = h; v.epc = ep; v.stall = s; v.flush = f; v.pc = pc; v.abort = a;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic i, logic e, logic x, logic er,
                       logic [31:0] h, logic [31:0] ep);
    rst_n = r; id = i; ex = e; excp = x; eret = er; handler = h; epc = ep;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_cnt;
    post_t      p;
    vec_t       v;

    // ---------------- vector table (dut_a) ----------------
    vecs.push_back(mk(0,0,1,0,0, 0,0, 6'h00, 0, 32'h0, 0));       // reset held, ex ignored
    vecs.push_back(mk(0,0,1,0,0, 0,0, 6'h00, 0, 32'h0, 0));
    vecs.push_back(mk(1,0,1,0,0, 0,0, 6'h0F, 0, 32'h0, 0));       // release: same-cycle stall
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h0, 0));
    vecs.push_back(mk(1,1,0,0,0, 0,0, 6'h07, 0, 32'h0, 0));       // load-use
    vecs.push_back(mk(1,1,1,0,0, 0,0, 6'h0F, 0, 32'h0, 0));       // both -> EX wins
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h0, 0));
    vecs.push_back(mk(1,0,1,1,0, 32'h20,0, 6'h00, 1, 32'h20, 0)); // exception beats stall
    vecs.push_back(mk(1,1,1,0,0, 0,0, 6'h00, 0, 32'h20, 0));      // FLUSH: requests ignored
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h20, 0));
    vecs.push_back(mk(1,0,0,0,1, 0,32'h1000, 6'h00, 1, 32'h1000, 0)); // eret
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h1000, 0));
    vecs.push_back(mk(1,0,0,1,1, 32'h80,32'h2000, 6'h00, 1, 32'h80, 0)); // excp wins
    vecs.push_back(mk(1,0,0,0,1, 0,32'h3000, 6'h00, 0, 32'h80, 0));  // eret in FLUSH ignored
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h80, 0));
    for (int k = 0; k < 10; k++)                                   // watchdog: pulses at 4, 8
      vecs.push_back(mk(1,0,1,0,0, 0,0, 6'h0F, 0, 32'h80, (k == 3 || k == 7)));
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h80, 0));
    for (int k = 0; k < 3; k++)                                    // dropped at 3: no pulse
      vecs.push_back(mk(1,0,1,0,0, 0,0, 6'h0F, 0, 32'h80, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h80, 0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 6'h00, 0, 32'h0, 0));        // reset, then saturation
    for (int k = 0; k < 20; k++)
      vecs.push_back(mk(1,1,0,0,0, 0,0, 6'h07, 0, 32'h0, 0));
    vecs.push_back(mk(1,0,1,0,0, 0,0, 6'h0F, 0, 32'h0, 0));        // wdog cleared by flush
    vecs.push_back(mk(1,0,1,0,0, 0,0, 6'h0F, 0, 32'h0, 0));
    vecs.push_back(mk(1,0,1,1,0, 32'h40,0, 6'h00, 1, 32'h40, 0));
    vecs.push_back(mk(1,0,1,0,0, 0,0, 6'h00, 0, 32'h40, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,0,1,0,0, 0,0, 6'h0F, 0, 32'h40, (k == 3)));
    vecs.push_back(mk(1,0,0,0,0, 0,0, 6'h00, 0, 32'h40, 0));

    drive(0,0,0,0,0,0,0);
    @(posedge clk);
    #1;
    exp_cnt = 4'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst_n, v.id, v.ex, v.excp, v.eret, v.handler, v.epc);
      #1;
      check($sformatf("stall[%0d]", i), bus_a.stall_o, v.stall);
      if (!v.rst_n) exp_cnt = 4'h0;
      else if (v.stall != 6'h00 && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'h1;
      p.idx = i; p.flush = v.flush; p.pc = v.pc; p.abort = v.abort; p.cnt = exp_cnt;
      sb.push_back(p);
      @(posedge clk);
      #1;
      p = sb.pop_front();
      check($sformatf("flush[%0d]", p.idx), bus_a.flush_o, p.flush);
      check($sformatf("new_pc[%0d]", p.idx), bus_a.new_pc_o, p.pc);
      check($sformatf("abort[%0d]", p.idx), bus_a.ex_abort_o, p.abort);
      check($sformatf("cnt[%0d]", p.idx), bus_a.stall_cnt_o, p.cnt);
      $display("[TB] vec %0d stall=%b flush=%b pc=%h abort=%b cnt=%0d",
               p.idx, v.stall, bus_a.flush_o, bus_a.new_pc_o, bus_a.ex_abort_o, bus_a.stall_cnt_o);
    end

    // ---------------- async reset mid-FLUSH (dut_a) ----------------
    drive(1,0,0,1,0, 32'h55,0);
    @(posedge clk);
    #1;
    drive(1,0,1,0,0, 0,0);
    check("mid_flush_high", bus_a.flush_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flush", bus_a.flush_o, 1'b0);
    check("arst_pc", bus_a.new_pc_o, 32'h0);
    check("arst_cnt", bus_a.stall_cnt_o, 4'h0);
    check("arst_stall", bus_a.stall_o, 6'h00);
    rst_n = 1'b1;
    #1;
    check("arst_run_stall", bus_a.stall_o, 6'h0F);
    @(posedge clk);
    #1;
    check("arst_no_pending", bus_a.flush_o, 1'b0);
    check("arst_cnt_after", bus_a.stall_cnt_o, 4'h1);
    $display("[TB] async reset mid-flush done");

    // ---------------- 3-cycle flush (dut_b) ----------------
    drive(0,0,0,0,0,0,0);
    @(posedge clk);
    #1;
    drive(1,0,1,1,0, 32'h100,0);
    #1;
    check("b_excp_stall", bus_b.stall_o, 6'h00);
    @(posedge clk);
    #1;
    excp = 1'b0;
    check("b_flush_e0", bus_b.flush_o, 1'b1);
    check("b_pc", bus_b.new_pc_o, 32'h100);
    for (int k = 1; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b_flush_e%0d", k), bus_b.flush_o, 1'b1);
      check($sformatf("b_stall_e%0d", k), bus_b.stall_o, 6'h00);
    end
    @(posedge clk);
    #1;
    check("b_flush_end", bus_b.flush_o, 1'b0);
    check("b_stall_run", bus_b.stall_o, 6'h0F);
    check("b_cnt0", bus_b.stall_cnt_o, 16'd0);
    check("b_pc_hold", bus_b.new_pc_o, 32'h100);
    @(posedge clk);
    #1;
    check("b_cnt1", bus_b.stall_cnt_o, 16'd1);
    $display("[TB] 3-cycle flush done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
